psc_trigger_frame_sequencer: RTL and testbench

PSC_TRIGGER_FRAME_SEQUENCER -- requirements
Module: psc_trigger_frame_sequencer

---
 rtl/psc_trigger_frame_sequencer_if.sv | 9 +
 rtl/psc_trigger_frame_sequencer.sv | 95 +++++++++
 tb/tb_psc_trigger_frame_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/psc_trigger_frame_sequencer_if.sv
// psc_trigger_frame_sequencer_if: byte stream from the frame sequencer to the serializer
interface psc_trigger_frame_sequencer_if;
  logic [7:0] data;
  logic       k;
  logic       valid;
  logic       ready;
  modport master(output data, k, valid, input ready);
  modport slave(input data, k, valid, output ready);
endinterface

// File: rtl/psc_trigger_frame_sequencer.sv
// psc_trigger_frame_sequencer: streams ROM-held trigger or keepalive frames with a 1-deep trigger queue
module psc_trigger_frame_sequencer #(
  parameter int FRAME_LEN   = 10,
  parameter int IDLE_PERIOD = 1000,
  parameter int MIN_GAP     = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 trigger_in,
  output logic [3:0]                           rom_address,
  output logic                                 rom_is_trigger,
  input  logic [7:0]                           rom_data,
  psc_trigger_frame_sequencer_if.master        tx,
  output logic                                 busy,
  output logic                                 trigger_dropped,
  output logic [15:0]                          frame_count
);
  localparam int TW = $clog2(IDLE_PERIOD + 1);
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam logic [3:0]    LAST      = 4'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(IDLE_PERIOD - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(MIN_GAP - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t        state, state_n;
  logic [3:0]    addr_n;
  logic          trig_n, pending, pend_n, drop_n;
  logic [TW-1:0] timer, timer_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [15:0]   count_n;
  assign tx.valid = state == SEND;
  assign tx.data  = rom_data;
  assign tx.k     = tx.valid && (rom_address == 4'd0 || rom_address == LAST);
  assign busy     = state != IDLE;
  always_comb begin
    state_n = state;
    addr_n  = rom_address;
    trig_n  = rom_is_trigger;
    pend_n  = pending;
    timer_n = timer;
    gap_n   = gap_cnt;
    drop_n  = 1'b0;
    count_n = frame_count;
    if (state == IDLE) begin
      // a queued trigger and a fresh one together: serve one, keep the other queued
      if (trigger_in || pending) begin
        state_n = SEND;
        addr_n  = 4'd0;
        trig_n  = 1'b1;
        pend_n  = pending && trigger_in;
        timer_n = '0;
      end else if (timer == TIMER_MAX) begin
        state_n = SEND;
        addr_n  = 4'd0;
        trig_n  = 1'b0;
        timer_n = '0;
      end else
        timer_n = timer + 1'b1;
    end else begin
      if (trigger_in) begin
        pend_n = 1'b1;
        drop_n = pending;
      end
      if (state == SEND && tx.ready) begin
        addr_n  = rom_address == LAST ? 4'd0 : rom_address + 4'd1;
        state_n = rom_address == LAST ? GAP : SEND;
        gap_n   = '0;
        count_n = rom_address == LAST ? frame_count + 16'd1 : frame_count;
      end else if (state == GAP) begin
        gap_n   = gap_cnt + 1'b1;
        state_n = gap_cnt == GAP_MAX ? IDLE : GAP;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rom_address     <= 4'd0;
      rom_is_trigger  <= 1'b0;
      pending         <= 1'b0;
      timer           <= '0;
      gap_cnt         <= '0;
      trigger_dropped <= 1'b0;
      frame_count     <= 16'd0;
    end else begin
      state           <= state_n;
      rom_address     <= addr_n;
      rom_is_trigger  <= trig_n;
      pending         <= pend_n;
      timer           <= timer_n;
      gap_cnt         <= gap_n;
      trigger_dropped <= drop_n;
      frame_count     <= count_n;
    end
  end
endmodule

// File: tb/tb_psc_trigger_frame_sequencer.sv
// tb_psc_trigger_frame_sequencer: scoreboard bench for the trigger frame sequencer
module tb_psc_trigger_frame_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger_in = 1'b0;
  logic [3:0]  rom_address;
  logic        rom_is_trigger;
  logic [7:0]  rom_data;
  logic        busy, trigger_dropped;
  logic [15:0] frame_count;
  psc_trigger_frame_sequencer_if tx();
  int errors = 0;
  int checks = 0;
  int fc_exp = 0;
  logic [8:0] sb[$];
  assign rom_data = {rom_is_trigger, 3'b101, rom_address};
  psc_trigger_frame_sequencer #(.FRAME_LEN(10), .IDLE_PERIOD(20), .MIN_GAP(2)) dut (
    .clk(clk), .reset(reset), .trigger_in(trigger_in), .rom_address(rom_address),
    .rom_is_trigger(rom_is_trigger), .rom_data(rom_data), .tx(tx.master), .busy(busy),
    .trigger_dropped(trigger_dropped), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  task automatic push_frame(input logic trig);
    for (int i = 0; i < 10; i++) sb.push_back({trig, 3'b101, 4'(i), i == 0 || i == 9});
  endtask
  task automatic cyc();
    logic [8:0] e;
    checks++;
    if (!tx.valid && tx.k) begin
      errors++;
      $display("FAIL k_without_valid: got k=1 expected k=0");
    end
    if (tx.valid && tx.ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got data=%0h, no byte expected", tx.data);
      end else begin
        e = sb.pop_front();
        if ({tx.data, tx.k} !== e) begin
          errors++;
          $display("FAIL xfer: got data=%0h k=%0b expected data=%0h k=%0b", tx.data, tx.k, e[8:1], e[0]);
        end else if (e[0] && e[4:1] == 4'd9) fc_exp++;
      end
    end
    @(negedge clk);
  endtask
  task automatic drain(input int budget);
    for (int n = 0; n < budget && sb.size() > 0; n++) cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes left expected 0", sb.size());
    end
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 40 && busy; n++) cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: got busy=%b expected 0", busy);
    end
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!tx.valid && n < 100) begin
      cyc();
      n++;
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({tx.valid, tx.k, busy, rom_is_trigger, trigger_dropped, rom_address, frame_count} !== 25'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b k=%b busy=%b trig=%b drop=%b addr=%0d fc=%0d expected all 0",
               tx.valid, tx.k, busy, rom_is_trigger, trigger_dropped, rom_address, frame_count);
    end
    reset = 1'b0;
  endtask
  task automatic test_single_trigger();
    push_frame(1'b1);
    trigger_in = 1'b1;
    cyc();
    trigger_in = 1'b0;
    checks++;
    if ({tx.valid, tx.k, busy, rom_is_trigger, rom_address} !== 8'b1111_0000) begin
      errors++;
      $display("FAIL trigger_latency: got valid=%b k=%b busy=%b trig=%b addr=%0d expected 1 1 1 1 0",
               tx.valid, tx.k, busy, rom_is_trigger, rom_address);
    end
    drain(40);
    checks++;
    if ({tx.valid, busy, frame_count} !== {2'b01, 16'(fc_exp)} || fc_exp != 1) begin
      errors++;
      $display("FAIL gap_entry: got valid=%b busy=%b fc=%0d expected valid=0 busy=1 fc=1", tx.valid, busy, frame_count);
    end
    cyc();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_len_2: got busy=%b expected 1", busy);
    end
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_end: got busy=%b expected 0", busy);
    end
  endtask
  task automatic test_keepalive();
    int n, m;
    logic low;
    push_frame(1'b0);
    push_frame(1'b0);
    wait_valid(n);
    checks++;
    if (n != 20 || rom_is_trigger !== 1'b0) begin
      errors++;
      $display("FAIL keepalive_start: got %0d cycles trig=%b expected 20 cycles trig=0", n, rom_is_trigger);
    end
    m = 0;
    low = 1'b0;
    do begin
      cyc();
      m++;
      if (!tx.valid) low = 1'b1;
    end while (!(low && tx.valid) && m < 100);
    checks++;
    if (m != 32) begin
      errors++;
      $display("FAIL keepalive_period: got %0d cycles expected 32", m);
    end
    drain(40);
    wait_idle();
    checks++;
    if (frame_count !== 16'(fc_exp) || fc_exp != 3) begin
      errors++;
      $display("FAIL keepalive_count: got fc=%0d expected 3", frame_count);
    end
  endtask
  task automatic test_stall();
    logic stalled = 1'b0;
    logic [7:0] pd;
    logic [3:0] pa;
    push_frame(1'b1);
    trigger_in = 1'b1;
    cyc();
    trigger_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tx.ready = i % 2 == 0;
      if (stalled) begin
        checks++;
        if (tx.data !== pd || rom_address !== pa || !tx.valid) begin
          errors++;
          $display("FAIL stall_hold: got data=%0h addr=%0d expected data=%0h addr=%0d", tx.data, rom_address, pd, pa);
        end
      end
      stalled = tx.valid && !tx.ready;
      pd = tx.data;
      pa = rom_address;
      cyc();
    end
    tx.ready = 1'b1;
    checks++;
    if (sb.size() != 0 || tx.valid !== 1'b0 || frame_count !== 16'd4) begin
      errors++;
      $display("FAIL stall_frame: got left=%0d valid=%b fc=%0d expected 0 0 4", sb.size(), tx.valid, frame_count);
    end
    wait_idle();
  endtask
  task automatic test_back_to_back_drop();
    push_frame(1'b1);
    push_frame(1'b1);
    trigger_in = 1'b1;
    cyc();
    trigger_in = 1'b0;
    cyc();
    cyc();
    trigger_in = 1'b1;
    cyc();
    trigger_in = 1'b0;
    cyc();
    checks++;
    if (trigger_dropped !== 1'b0) begin
      errors++;
      $display("FAIL drop_early: got %b expected 0", trigger_dropped);
    end
    trigger_in = 1'b1;
    cyc();
    trigger_in = 1'b0;
    checks++;
    if (trigger_dropped !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: got %b expected 1", trigger_dropped);
    end
    cyc();
    checks++;
    if (trigger_dropped !== 1'b0) begin
      errors++;
      $display("FAIL drop_width: got %b expected 0", trigger_dropped);
    end
    drain(60);
    wait_idle();
    checks++;
    if (frame_count !== 16'(fc_exp) || fc_exp != 6) begin
      errors++;
      $display("FAIL follow_on_count: got fc=%0d expected 6", frame_count);
    end
  endtask
  task automatic test_coincident_and_reset();
    int n;
    push_frame(1'b1);
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (tx.valid !== 1'b0) begin
        errors++;
        $display("FAIL extra_frame: got valid=%b at idle cycle %0d expected 0", tx.valid, i);
      end
      cyc();
    end
    trigger_in = 1'b1;
    cyc();
    trigger_in = 1'b0;
    checks++;
    if (tx.valid !== 1'b1 || rom_is_trigger !== 1'b1) begin
      errors++;
      $display("FAIL coincident: got valid=%b trig=%b expected 1 1", tx.valid, rom_is_trigger);
    end
    for (int i = 0; i < 20 && rom_address != 4'd5; i++) cyc();
    reset = 1'b1;
    #1;
    checks++;
    if ({tx.valid, tx.k, busy, rom_is_trigger, trigger_dropped, rom_address, frame_count} !== 25'd0) begin
      errors++;
      $display("FAIL reset_abort: got valid=%b k=%b busy=%b trig=%b addr=%0d fc=%0d expected all 0",
               tx.valid, tx.k, busy, rom_is_trigger, rom_address, frame_count);
    end
    sb.delete();
    fc_exp = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    push_frame(1'b0);
    wait_valid(n);
    checks++;
    if (n != 20 || rom_is_trigger !== 1'b0) begin
      errors++;
      $display("FAIL resume_keepalive: got %0d cycles trig=%b expected 20 cycles trig=0", n, rom_is_trigger);
    end
    drain(40);
    wait_idle();
    checks++;
    if (frame_count !== 16'(fc_exp) || fc_exp != 1) begin
      errors++;
      $display("FAIL resume_count: got fc=%0d expected 1", frame_count);
    end
  endtask
  initial begin
    tx.ready = 1'b1;
    test_reset();
    test_single_trigger();
    test_keepalive();
    test_stall();
    test_back_to_back_drop();
    test_coincident_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
